// File: rtl/cv32e40px_hwloop_jump_ctrl.sv
// Hardware-loop jump/decrement controller between fetch and the hwloop regfile.
// Ports: fetch pc/valid/ready, ID retire, flush, regfile counter write +
//   loop start/end/counter inputs; outputs jump, target, decrement strobe.
module cv32e40px_hwloop_jump_ctrl #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS),
  parameter int FIFO_DEPTH = 2,
  parameter int PEND_BITS  = $clog2(FIFO_DEPTH+1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  pc_if_i,
  input  logic                         if_valid_i,
  output logic                         if_ready_o,
  input  logic                         id_valid_i,
  input  logic                         flush_i,
  input  logic                         hwlp_we_cnt_i,
  input  logic [N_REG_BITS-1:0]        hwlp_regid_i,
  input  logic [N_REGS-1:0][31:0]      hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0]      hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]      hwlp_counter_i,
  output logic                         hwlp_jump_o,
  output logic [31:0]                  hwlp_targ_addr_o,
  output logic [N_REGS-1:0]            hwlp_dec_cnt_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [FIFO_DEPTH-1:0] r_dec;
  logic [N_REG_BITS-1:0] r_id [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [PEND_BITS-1:0]  r_cnt;
  logic [PEND_BITS-1:0]  r_pend [N_REGS];

  logic [31:0]           w_eff [N_REGS];
  logic [N_REGS-1:0]     w_hit;
  logic [N_REG_BITS-1:0] w_sel;
  logic                  w_any_hit;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_push_dec;
  logic                  w_pop_dec;
  logic [N_REG_BITS-1:0] w_head_id;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_REGS; k++) begin
      w_eff[k] = hwlp_counter_i[k] - 32'(r_pend[k]);
      w_hit[k] = (pc_if_i == hwlp_end_addr_i[k])
              && (w_eff[k] != 32'd0);
    end
    // Walk downward so the innermost (lowest) hit wins.
    for (int k = N_REGS-1; k >= 0; k--) begin
      if (w_hit[k]) w_sel = N_REG_BITS'(k);
    end
    w_any_hit = |w_hit;
  end

  assign w_full    = (r_cnt == PEND_BITS'(FIFO_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_push    = if_valid_i && !flush_i;
  assign w_pop     = id_valid_i && !w_empty && !flush_i;
  assign w_head_id = r_id[r_rptr];
  assign w_pop_dec = w_pop && r_dec[r_rptr];

  // A counter write to the selected loop makes this fetch untagged.
  assign w_push_dec = w_push && w_any_hit
    && !(hwlp_we_cnt_i && (hwlp_regid_i == w_sel));

  assign if_ready_o  = !w_full;
  assign hwlp_jump_o = if_valid_i && w_any_hit
    && (w_eff[w_sel] > 32'd1);
  assign hwlp_targ_addr_o = hwlp_jump_o
    ? hwlp_start_addr_i[w_sel] : 32'd0;
  assign hwlp_dec_cnt_o = w_pop_dec
    ? (N_REGS'(1) << w_head_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_id[i] <= '0;
      for (int k = 0; k < N_REGS; k++) r_pend[k] <= '0;
    end else if (flush_i) begin
      r_dec  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int k = 0; k < N_REGS; k++) r_pend[k] <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (hwlp_we_cnt_i && (r_id[i] == hwlp_regid_i))
          r_dec[i] <= 1'b0;
      end
      if (w_pop) begin
        r_dec[r_rptr] <= 1'b0;
        r_rptr        <= nxt(r_rptr);
      end
      // Push last: when full, push and pop share a slot.
      if (w_push) begin
        r_dec[r_wptr] <= w_push_dec;
        r_id[r_wptr]  <= w_sel;
        r_wptr        <= nxt(r_wptr);
      end
      if (w_push && !w_pop)
        r_cnt <= r_cnt + PEND_BITS'(1);
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - PEND_BITS'(1);
      for (int k = 0; k < N_REGS; k++) begin
        logic l_inc;
        logic l_dec;
        l_inc = w_push_dec && (w_sel == N_REG_BITS'(k));
        l_dec = w_pop_dec && (w_head_id == N_REG_BITS'(k));
        if (hwlp_we_cnt_i && (hwlp_regid_i == N_REG_BITS'(k)))
          r_pend[k] <= '0;
        else if (l_inc && !l_dec)
          r_pend[k] <= r_pend[k] + PEND_BITS'(1);
        else if (!l_inc && l_dec)
          r_pend[k] <= r_pend[k] - PEND_BITS'(1);
      end
    end
  end

  function automatic int tag_count(input int k);
    int n;
    n = 0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (r_dec[i] && (int'(r_id[i]) == k)) n++;
    return n;
  endfunction

  for (genvar g = 0; g < N_REGS; g++) begin : g_chk
    a_pend: assert property (@(posedge clk) disable iff (!rst_n)
      int'(r_pend[g]) == tag_count(g));
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(hwlp_dec_cnt_o) <= 1);

  a_nofull: assert property (@(posedge clk) disable iff (!rst_n)
    (w_push && w_full) |-> w_pop);

endmodule

// File: tb/tb_cv32e40px_hwloop_jump_ctrl.sv
// Directed scoreboard bench for cv32e40px_hwloop_jump_ctrl.
// Includes a minimal register-file counter model driven by the decrement strobe.
module tb_cv32e40px_hwloop_jump_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]      pc_if = '0;
  logic             if_valid = 1'b0;
  logic             id_valid = 1'b0;
  logic             flush = 1'b0;
  logic             we_cnt = 1'b0;
  logic [0:0]       regid = '0;
  logic [31:0]      wdata = '0;
  logic [1:0][31:0] start_a = '0;
  logic [1:0][31:0] end_a = '0;
  logic [1:0][31:0] cnt_a = '0;
  logic             if_ready;
  logic             jump;
  logic [31:0]      targ;
  logic [1:0]       dec;

  cv32e40px_hwloop_jump_ctrl #(
    .N_REGS(2), .FIFO_DEPTH(2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_if_i          (pc_if),
    .if_valid_i       (if_valid),
    .if_ready_o       (if_ready),
    .id_valid_i       (id_valid),
    .flush_i          (flush),
    .hwlp_we_cnt_i    (we_cnt),
    .hwlp_regid_i     (regid),
    .hwlp_start_addr_i(start_a),
    .hwlp_end_addr_i  (end_a),
    .hwlp_counter_i   (cnt_a),
    .hwlp_jump_o      (jump),
    .hwlp_targ_addr_o (targ),
    .hwlp_dec_cnt_o   (dec)
  );

  // Register-file stand-in: write has priority over decrement.
  always @(posedge clk) begin
    if (we_cnt) cnt_a[regid] <= wdata;
    else begin
      for (int k = 0; k < 2; k++)
        if (dec[k]) cnt_a[k] <= cnt_a[k] - 32'd1;
    end
  end

  typedef struct {
    logic        j;
    logic [31:0] t;
    logic [1:0]  d;
    logic        r;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  done = 1'b0;
  logic  chk_done = 1'b0;

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (rst_n && (if_valid || id_valid || flush)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output t=%0t j=%0b t=%h d=%b",
                 $time, jump, targ, dec);
      end else begin
        e  = q.pop_front();
        nm = nq.pop_front();
        if (jump !== e.j || targ !== e.t
            || dec !== e.d || if_ready !== e.r) begin
          n_bad++;
          $display("FAIL %s: got j=%0b t=%h d=%b r=%0b exp j=%0b t=%h d=%b r=%0b",
                   nm, jump, targ, dec, if_ready, e.j, e.t, e.d, e.r);
        end
      end
    end
    if (done && !chk_done) begin
      chk_done = 1'b1;
      n_cmp++;
      if (q.size() != 0) begin
        n_bad++;
        $display("FAIL leftover: got %0d pending expectations exp 0",
                 q.size());
      end
    end
  end

  task automatic cyc(
    input logic [31:0] pc, input logic iv, input logic dv,
    input logic fl, input logic ej, input logic [31:0] et,
    input logic [1:0] ed, input logic er, input string nm,
    input logic we = 1'b0, input logic rid = 1'b0,
    input logic [31:0] wd = 32'd0
  );
    exp_t e;
    @(posedge clk);
    #1;
    pc_if    = pc;
    if_valid = iv;
    id_valid = dv;
    flush    = fl;
    we_cnt   = we;
    regid    = rid;
    wdata    = wd;
    if (iv || dv || fl) begin
      e = '{ej, et, ed, er};
      q.push_back(e);
      nq.push_back(nm);
    end
  endtask

  task automatic wr(input logic rid, input logic [31:0] wd);
    cyc(32'd0, 0, 0, 0, 0, 32'd0, 2'b00, 1, "wr", 1'b1, rid, wd);
  endtask

  // Configuration changes land after the monitor has sampled.
  task automatic cfg(
    input logic [31:0] s0, input logic [31:0] e0,
    input logic [31:0] s1, input logic [31:0] e1
  );
    @(negedge clk);
    #1;
    start_a[0] = s0;
    end_a[0]   = e0;
    start_a[1] = s1;
    end_a[1]   = e1;
  endtask

  initial begin
    start_a[0] = 32'h100;
    end_a[0]   = 32'h108;
    start_a[1] = 32'h300;
    end_a[1]   = 32'h400;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    cyc(0, 0, 1, 0, 0, 0, 2'b00, 1, "reset_state");
    wr(0, 32'd3);
    wr(1, 32'd0);

    cyc('h100, 1, 1, 0, 0, 0,     2'b00, 1, "t1_c1");
    cyc('h104, 1, 1, 0, 0, 0,     2'b00, 1, "t1_c2");
    cyc('h108, 1, 1, 0, 1, 'h100, 2'b00, 1, "t1_c3");
    cyc('h100, 1, 1, 0, 0, 0,     2'b01, 1, "t1_c4");
    cyc('h104, 1, 1, 0, 0, 0,     2'b00, 1, "t1_c5");
    cyc('h108, 1, 1, 0, 1, 'h100, 2'b00, 1, "t1_c6");
    cyc('h100, 1, 1, 0, 0, 0,     2'b01, 1, "t1_c7");
    cyc('h104, 1, 1, 0, 0, 0,     2'b00, 1, "t1_c8");
    cyc('h108, 1, 1, 0, 0, 0,     2'b00, 1, "t1_last");
    cyc('h10c, 1, 1, 0, 0, 0,     2'b01, 1, "t1_c10");
    cyc('h110, 1, 1, 0, 0, 0,     2'b00, 1, "t1_c11");
    cyc(0,     0, 1, 0, 0, 0,     2'b00, 1, "t1_drain");

    wr(0, 32'd2);
    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t2_jump");
    cyc('h108, 1, 0, 0, 0, 0,     2'b00, 1, "t2_eff1");
    cyc(0,     0, 1, 0, 0, 0,     2'b01, 0, "t2_ret1");
    cyc(0,     0, 1, 0, 0, 0,     2'b01, 1, "t2_ret2");
    cyc(0,     0, 1, 0, 0, 0,     2'b00, 1, "t2_empty");

    cfg('h200, 'h120, 'h300, 'h120);
    wr(0, 32'd2);
    wr(1, 32'd5);
    cyc('h120, 1, 0, 0, 1, 'h200, 2'b00, 1, "t3_jump0");
    cyc(0,     0, 1, 0, 0, 0,     2'b01, 1, "t3_ret1");
    cyc('h120, 1, 0, 0, 0, 0,     2'b00, 1, "t3_last0");
    cyc(0,     0, 1, 0, 0, 0,     2'b01, 1, "t3_ret2");
    cyc('h120, 1, 0, 0, 1, 'h300, 2'b00, 1, "t3_jump1");
    cyc(0,     0, 1, 0, 0, 0,     2'b10, 1, "t3_ret3");

    cfg('h100, 'h108, 'h300, 'h400);
    wr(0, 32'd5);
    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t4_c1");
    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t4_c2");
    cyc('h108, 1, 1, 1, 1, 'h100, 2'b00, 0, "t4_flush");
    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t4_raw");
    cyc(0,     0, 1, 0, 0, 0,     2'b01, 1, "t4_ret");
    cyc(0,     0, 1, 0, 0, 0,     2'b00, 1, "t4_empty");

    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t5_c1");
    wr(0, 32'd7);
    cyc(0,     0, 1, 0, 0, 0,     2'b00, 1, "t5_cleared");
    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t5_eff7");
    cyc(0,     0, 1, 0, 0, 0,     2'b01, 1, "t5_ret");
    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t5_c6");
    cyc(0,     0, 1, 0, 0, 0,     2'b01, 1, "t5_popwr", 1'b1, 1'b0, 32'd3);
    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t5_eff3");
    cyc(0,     0, 1, 0, 0, 0,     2'b01, 1, "t5_c9");
    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t5_pushwr", 1'b1, 1'b0, 32'd9);
    cyc(0,     0, 1, 0, 0, 0,     2'b00, 1, "t5_untag");
    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t5_eff9");
    cyc(0,     0, 1, 0, 0, 0,     2'b01, 1, "t5_c13");

    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t6_p0");
    cyc('h400, 1, 0, 0, 1, 'h300, 2'b00, 1, "t6_p1");
    cyc('h500, 1, 1, 0, 0, 0,     2'b01, 0, "t6_full_pp1");
    cyc('h108, 1, 1, 0, 1, 'h100, 2'b10, 0, "t6_full_pp2");
    cyc(0,     0, 1, 0, 0, 0,     2'b00, 0, "t6_pop_untag");
    cyc(0,     0, 1, 0, 0, 0,     2'b01, 1, "t6_pop_l0");
    cyc(0,     0, 1, 0, 0, 0,     2'b00, 1, "t6_empty");

    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t7_c1");
    @(posedge clk);
    #1;
    pc_if    = '0;
    if_valid = 1'b0;
    id_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    cyc(0,     0, 1, 0, 0, 0,     2'b00, 1, "t7_after_rst");
    cyc('h108, 1, 0, 0, 1, 'h100, 2'b00, 1, "t7_raw");
    cyc(0,     0, 1, 0, 0, 0,     2'b01, 1, "t7_ret");

    @(posedge clk);
    #1;
    pc_if    = '0;
    if_valid = 1'b0;
    id_valid = 1'b0;
    flush    = 1'b0;
    we_cnt   = 1'b0;
    done     = 1'b1;
    for (int i = 0; i < 5 && !chk_done; i++) @(posedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
